spi_master_mcs: RTL and testbench
=================================

Name: spi_master_mcs

Overview:
- Next-generation parametrised SPI master: full-duplex shift of 1..P_DATA_WIDTH bits, selectable MSB/LSB-first order, CPOL/CPHA modes, and P_NCS chip-select outputs with programmable setup and hold times.
- Self-timed by one half-period counter; needs no iterative max-count calculation.
- Sits between the register/command layer (req/ack level handshake) and the board-level SPI pins.

Parameters:
- P_DATA_WIDTH, 256, maximum bits per transaction; width of wr_data and rd_data.
- P_NCS, 4, number of chip-select outputs (1..256).
- P_CNT_WIDTH, 16, width of the timing inputs n_half, n_setup and n_hold.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  transaction request; level, held until ack.
- cs_sel  in  8  index of the chip select to assert.
- nbits  in  16  bits to shift, valid range 1..P_DATA_WIDTH.
- cpol  in  1  sclk idle level.
- cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- lsb_first  in  1  1 = shift LSB first.
- n_half  in  P_CNT_WIDTH  sclk half-period in clk cycles, >=1.
- n_setup  in  P_CNT_WIDTH  cycles from cs assert to first sclk edge.
- n_hold  in  P_CNT_WIDTH  cycles from last sclk edge to cs deassert.
- wr_data  in  P_DATA_WIDTH  transmit word, right-justified.
- rd_data  out  P_DATA_WIDTH  received word, right-justified.
- ack  out  1  transaction done.
- busy  out  1  transaction in progress.
- err  out  1  last request rejected.
- sclk  out  1  SPI clock.
- mosi  out  1  master out.
- miso  in  1  master in.
- cs_n  out  P_NCS  active-low chip selects.

Behaviour:
- Reset values: cs_n all 1; sclk 0; mosi 0; ack 0; busy 0; err 0; rd_data 0; FSM in IDLE.
- Reset is honoured at any time, including mid-transaction: pins return to reset values immediately, with no hold phase.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, HOLD, ACK.
- IDLE:
  - sclk = latched cpol (0 after reset); cs_n all 1.
  - On req=1, config is checked. It is invalid if nbits==0, nbits>P_DATA_WIDTH, n_half==0, or cs_sel>=P_NCS.
  - Invalid request: next state ACK with err=1; cs_n, sclk and mosi are untouched; rd_data is unchanged.
  - Valid request: all inputs are latched; err cleared; busy=1; sclk set to cpol; cs_n[cs_sel]=0 on the next cycle; next state SETUP.
  - If cpha=0, mosi drives the first bit on SETUP entry.
- Bit order:
  - MSB-first transmits wr_data[nbits-1] first.
  - LSB-first transmits wr_data[0] first.
- SETUP: lasts max(n_setup,1) cycles, then SHIFT.
- SHIFT:
  - The half-period counter toggles sclk every n_half cycles, 2*nbits toggles in total.
  - SHIFT lasts exactly 2*nbits*n_half cycles, and the final toggle coincides with leaving SHIFT.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - cpha=0: miso is sampled on leading edges (the clk edge that toggles sclk); mosi advances on trailing edges, except the last one.
  - cpha=1: mosi advances on leading edges (the first leading edge drives bit 0); miso is sampled on trailing edges.
  - The sclk level after SHIFT equals cpol.
- HOLD:
  - Lasts max(n_hold,1) cycles with cs still asserted.
  - On exit: cs_n all 1, mosi 0, busy 0, and rd_data updated with the received word; next state ACK.
- ACK:
  - ack=1 is held while req=1 (no retrigger while req stays high).
  - When req=0: ack goes 0 next cycle and the FSM returns to IDLE.
- rd_data mapping:
  - MSB-first: the first received bit lands at rd_data[nbits-1].
  - LSB-first: the first received bit lands at rd_data[0].
  - Bits at positions >= nbits are 0.
  - rd_data holds its value until the next valid transaction completes.
- err persists until the next valid request is accepted.
- Config inputs may change freely outside IDLE; they are ignored there.
- Counters saturate and do not wrap; n_half at its maximum value is legal.

Test Plan:
- Mode 0, cs_sel=1, nbits=8, wr_data=0xA5, n_half=2, n_setup=3, n_hold=3, miso looped to mosi:
  - cs_n=4'b1101 for 3+32+3 cycles; 16 sclk toggles; rd_data=0xA5; ack high until req drops.
- Mode 3, lsb_first=1, nbits=12, wr_data=0x3C1, miso driven from a slave model returning 0x5A6:
  - mosi sequence 1,0,0,0,0,0,1,1,1,1,0,0; rd_data=0x5A6; sclk idles at 1 before and after.
- nbits=P_DATA_WIDTH=256, n_half=1, alternating 0xAAAA… pattern, loopback:
  - rd_data equals wr_data; SHIFT lasts 512 cycles.
- Invalid requests, one at a time: cs_sel=4 / nbits=0 / nbits=257 / n_half=0:
  - err=1 and ack=1 within 2 cycles; cs_n stays 4'b1111; sclk toggles 0 times; rd_data unchanged.
- rst asserted at bit 5 of a 16-bit transfer:
  - cs_n=all 1, busy=0, ack=0 immediately.
  - A subsequent valid 8-bit transfer completes correctly.
- req held high for 20 cycles after ack:
  - Exactly one transaction occurs; dropping req clears ack next cycle; reasserting req starts a new transaction.

Source files
------------

// File: rtl/spi_master_mcs.sv
// SPI master with multiple chip selects.
// Shifts 1..P_DATA_WIDTH bits full duplex, MSB- or LSB-first, in any CPOL/CPHA
// mode. Chip-select setup and hold times are programmable. A single half-period
// counter times the whole transfer. The command side uses a level req/ack
// handshake.
module spi_master_mcs #(
  parameter int P_DATA_WIDTH = 256,
  parameter int P_NCS        = 4,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic [7:0]              cs_sel,
  input  logic [15:0]             nbits,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    lsb_first,
  input  logic [P_CNT_WIDTH-1:0]  n_half,
  input  logic [P_CNT_WIDTH-1:0]  n_setup,
  input  logic [P_CNT_WIDTH-1:0]  n_hold,
  input  logic [P_DATA_WIDTH-1:0] wr_data,
  output logic [P_DATA_WIDTH-1:0] rd_data,
  output logic                    ack,
  output logic                    busy,
  output logic                    err,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [P_NCS-1:0]        cs_n
);

  localparam int                     IDX_W    = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
  localparam int                     TOG_W    = 17;
  localparam logic [15:0]            MAX_BITS = 16'(P_DATA_WIDTH);
  localparam logic [8:0]             NCS_LIM  = 9'(P_NCS);
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE  = P_CNT_WIDTH'(1);
  localparam logic [P_NCS-1:0]       CS_ONE   = P_NCS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_ACK
  } state_t;

  // Word position of the i-th bit on the wire for the given length and order.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [15:0] n,
                                               input logic [15:0] i,
                                               input logic        lsb);
    logic [15:0] p;
    p = lsb ? i : (n - 16'd1 - i);
    return p[IDX_W-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [15:0]             nbits_q, nbits_d;
  logic                    cpol_q, cpol_d;
  logic                    cpha_q, cpha_d;
  logic                    lsb_q, lsb_d;
  logic [P_CNT_WIDTH-1:0]  n_half_q, n_half_d;
  logic [P_CNT_WIDTH-1:0]  n_setup_q, n_setup_d;
  logic [P_CNT_WIDTH-1:0]  n_hold_q, n_hold_d;
  logic [P_DATA_WIDTH-1:0] tx_q, tx_d;
  logic [P_DATA_WIDTH-1:0] rx_q, rx_d;
  logic [P_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [P_CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TOG_W-1:0]        tog_q, tog_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic [P_NCS-1:0]        cs_n_q, cs_n_d;

  logic                    cfg_bad;
  logic [15:0]             bit_i;
  logic                    leading;
  logic [TOG_W-1:0]        tog_next;

  // Reject a request that cannot be executed with the current configuration.
  always_comb begin
    cfg_bad = (nbits == 16'd0) || (nbits > MAX_BITS) ||
              (n_half == '0) || ({1'b0, cs_sel} >= NCS_LIM);
  end

  // State and datapath registers; every register returns to its reset value at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tx/rx buffers are ordinary flops rather than a memory, so
      // they are reset with everything else and rd_data is defined from reset.
      state_q   <= S_IDLE;
      nbits_q   <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      n_half_q  <= '0;
      n_setup_q <= '0;
      n_hold_q  <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      tog_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      nbits_q   <= nbits_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      n_half_q  <= n_half_d;
      n_setup_q <= n_setup_d;
      n_hold_q  <= n_hold_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    // NOTE: every _d starts from its _q value, so any path that skips an
    // assignment simply holds state and no latch is inferred.
    state_d   = state_q;
    nbits_d   = nbits_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    n_half_d  = n_half_q;
    n_setup_d = n_setup_q;
    n_hold_d  = n_hold_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    err_d     = err_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    bit_i     = tog_q[16:1];
    leading   = ~tog_q[0];
    tog_next  = tog_q + 17'd1;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (cfg_bad) begin
            // Rejected: pins and rd_data stay as they are.
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            nbits_d   = nbits;
            cpol_d    = cpol;
            cpha_d    = cpha;
            lsb_d     = lsb_first;
            n_half_d  = n_half;
            n_setup_d = (n_setup == '0) ? CNT_ONE : n_setup;
            n_hold_d  = (n_hold == '0) ? CNT_ONE : n_hold;
            tx_d      = wr_data;
            rx_d      = '0;
            cnt_d     = '0;
            tog_d     = '0;
            err_d     = 1'b0;
            busy_d    = 1'b1;
            sclk_d    = cpol;
            cs_n_d    = ~(CS_ONE << cs_sel);
            // With cpha=0 the first bit must be on the wire before the first edge.
            if (!cpha) begin
              mosi_d = wr_data[bit_pos(nbits, 16'd0, lsb_first)];
            end
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == n_setup_q - CNT_ONE) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SHIFT: begin
        if (cnt_q == n_half_q - CNT_ONE) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          tog_d  = tog_next;
          if (leading) begin
            if (cpha_q) begin
              mosi_d = tx_q[bit_pos(nbits_q, bit_i, lsb_q)];
            end else begin
              rx_d[bit_pos(nbits_q, bit_i, lsb_q)] = miso;
            end
          end else begin
            if (cpha_q) begin
              rx_d[bit_pos(nbits_q, bit_i, lsb_q)] = miso;
            end else if (tog_next != {nbits_q, 1'b0}) begin
              mosi_d = tx_q[bit_pos(nbits_q, bit_i + 16'd1, lsb_q)];
            end
          end
          // The final toggle is the edge that leaves SHIFT.
          if (tog_next == {nbits_q, 1'b0}) begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HOLD: begin
        if (cnt_q == n_hold_q - CNT_ONE) begin
          cnt_d     = '0;
          cs_n_d    = '1;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          rd_data_d = rx_q;
          ack_d     = 1'b1;
          state_d   = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_ACK: begin
        // Hold ack until the requester drops req; no retrigger meanwhile.
        if (!req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_data = rd_data_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_mcs.sv
// Self-checking bench for spi_master_mcs.
// A behavioural SPI slave watches the pins cycle by cycle. It drives miso, or
// the bench loops mosi back to miso, and it records the bits it receives.
// Expected words and timings are computed from the protocol rules.
module tb_spi_master_mcs;

  localparam int W   = 256;
  localparam int NCS = 4;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req = 1'b0;
  logic [7:0]     cs_sel = '0;
  logic [15:0]    nbits = 16'd8;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic           lsb_first = 1'b0;
  logic [CW-1:0]  n_half = 16'd1;
  logic [CW-1:0]  n_setup = 16'd1;
  logic [CW-1:0]  n_hold = 16'd1;
  logic [W-1:0]   wr_data = '0;
  logic [W-1:0]   rd_data;
  logic           ack, busy, err, sclk, mosi, miso;
  logic [NCS-1:0] cs_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_mcs #(
    .P_DATA_WIDTH(W),
    .P_NCS       (NCS),
    .P_CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .cs_sel   (cs_sel),
    .nbits    (nbits),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsb_first(lsb_first),
    .n_half   (n_half),
    .n_setup  (n_setup),
    .n_hold   (n_hold),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ack      (ack),
    .busy     (busy),
    .err      (err),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  // Slave configuration, set by the stimulus before each request.
  logic         loopback = 1'b1;
  logic         s_cpha = 1'b0;
  logic         s_lsb = 1'b0;
  int           s_nbits = 8;
  logic [W-1:0] s_tx = '0;

  // Slave and pin-monitor state.
  logic         miso_s = 1'b0;
  logic         cs_prev = 1'b0;
  logic         sclk_prev = 1'b0;
  int           s_edge = 0;
  int           s_itx = 0;
  int           s_irx = 0;
  logic [W-1:0] s_rx = '0;
  int           tog_total = 0;
  int           chg_total = 0;
  int           cs_low_total = 0;

  logic [W-1:0] last_rd = '0;

  assign miso = loopback ? mosi : miso_s;

  // Position in the word of the i-th bit on the wire.
  function automatic int wire_pos(input int n, input int i, input logic lsb);
    return lsb ? i : (n - 1 - i);
  endfunction

  // Pin monitor and slave model, evaluated away from the active clock edge.
  always @(negedge clk) begin
    logic act;
    logic lead;
    act = (cs_n !== '1);
    if (sclk !== sclk_prev) chg_total++;
    if (act) cs_low_total++;
    if (act && !cs_prev) begin
      s_edge = 0;
      s_itx  = 0;
      s_irx  = 0;
      s_rx   = '0;
      if (!s_cpha) begin
        miso_s = s_tx[wire_pos(s_nbits, 0, s_lsb)];
        s_itx  = 1;
      end
    end else if (act && (sclk !== sclk_prev)) begin
      tog_total++;
      s_edge++;
      lead = (s_edge % 2) == 1;
      if ((s_cpha ? !lead : lead) && s_irx < s_nbits) begin
        s_rx[wire_pos(s_nbits, s_irx, s_lsb)] = mosi;
        s_irx++;
      end
      if ((s_cpha ? lead : !lead) && s_itx < s_nbits) begin
        miso_s = s_tx[wire_pos(s_nbits, s_itx, s_lsb)];
        s_itx++;
      end
    end
    cs_prev   = act;
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [W-1:0] observed,
                       input logic [W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One valid transaction: drive config, raise req, wait for ack, compare.
  task automatic run_txn(input string tag, input int cs, input int nb,
                         input logic pol, input logic pha, input logic lsb,
                         input int nh, input int ns, input int nhd,
                         input logic [W-1:0] wd, input logic lb,
                         input logic [W-1:0] stx, input int hold_req);
    logic [W-1:0]   mask;
    logic [NCS-1:0] exp_cs;
    int             cs0, t0, cs1, exp_low;
    logic           got;
    mask = '0;
    for (int i = 0; i < nb; i++) mask[i] = 1'b1;
    exp_cs  = ~(NCS'(1) << cs);
    exp_low = (ns == 0 ? 1 : ns) + 2 * nb * nh + (nhd == 0 ? 1 : nhd);

    cs_sel    = 8'(cs);
    nbits     = 16'(nb);
    cpol      = pol;
    cpha      = pha;
    lsb_first = lsb;
    n_half    = CW'(nh);
    n_setup   = CW'(ns);
    n_hold    = CW'(nhd);
    wr_data   = wd;
    loopback  = lb;
    s_cpha    = pha;
    s_lsb     = lsb;
    s_nbits   = nb;
    s_tx      = stx;
    cs0       = cs_low_total;
    t0        = tog_total;

    req = 1'b1;
    tick(1);
    check({tag, " cs_n_active"}, W'(cs_n), W'(exp_cs));
    check({tag, " busy_set"}, W'(busy), W'(1));
    check({tag, " err_clear"}, W'(err), W'(0));
    check({tag, " sclk_idle_pre"}, W'(sclk), W'(pol));

    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      if (ack === 1'b1) got = 1'b1;
      else tick(1);
    end
    check({tag, " ack_timeout"}, W'(got), W'(1));

    last_rd = (lb ? wd : stx) & mask;
    check({tag, " rd_data"}, rd_data, last_rd);
    check({tag, " mosi_seq"}, s_rx, wd & mask);
    check({tag, " cs_low_cycles"}, W'(cs_low_total - cs0), W'(exp_low));
    check({tag, " sclk_toggles"}, W'(tog_total - t0), W'(2 * nb));
    check({tag, " cs_n_released"}, W'(cs_n), W'({NCS{1'b1}}));
    check({tag, " busy_clear"}, W'(busy), W'(0));
    check({tag, " sclk_idle_post"}, W'(sclk), W'(pol));
    check({tag, " mosi_idle"}, W'(mosi), W'(0));

    cs1 = cs_low_total;
    tick(hold_req);
    check({tag, " ack_held"}, W'(ack), W'(1));
    check({tag, " no_retrigger"}, W'(cs_low_total - cs1), W'(0));

    req = 1'b0;
    tick(1);
    check({tag, " ack_drop"}, W'(ack), W'(0));
    check({tag, " sclk_idle_ret"}, W'(sclk), W'(pol));
  endtask

  // One rejected request: expect err/ack quickly and no pin activity.
  task automatic bad_req(input string tag, input int cs, input int nb, input int nh);
    int   ch0, cs0;
    logic got;
    cs_sel  = 8'(cs);
    nbits   = 16'(nb);
    n_half  = CW'(nh);
    n_setup = CW'(1);
    n_hold  = CW'(1);
    wr_data = rand_word();
    ch0     = chg_total;
    cs0     = cs_low_total;
    req     = 1'b1;
    got     = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      tick(1);
      if (ack === 1'b1) got = 1'b1;
    end
    check({tag, " ack_within_2"}, W'(got), W'(1));
    check({tag, " err_set"}, W'(err), W'(1));
    check({tag, " cs_n_idle"}, W'(cs_n), W'({NCS{1'b1}}));
    check({tag, " rd_unchanged"}, rd_data, last_rd);
    tick(2);
    check({tag, " sclk_no_toggle"}, W'(chg_total - ch0), W'(0));
    check({tag, " cs_never_low"}, W'(cs_low_total - cs0), W'(0));
    req = 1'b0;
    tick(1);
    check({tag, " ack_drop"}, W'(ack), W'(0));
    check({tag, " err_persists"}, W'(err), W'(1));
  endtask

  initial begin
    logic [W-1:0] alt;
    int           t0;
    logic         got;

    // Reset state.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset cs_n", W'(cs_n), W'({NCS{1'b1}}));
    check("reset sclk", W'(sclk), W'(0));
    check("reset mosi", W'(mosi), W'(0));
    check("reset ack", W'(ack), W'(0));
    check("reset busy", W'(busy), W'(0));
    check("reset err", W'(err), W'(0));
    check("reset rd_data", rd_data, W'(0));

    // Mode 0, loopback; req held 20 cycles after ack.
    run_txn("mode0", 1, 8, 1'b0, 1'b0, 1'b0, 2, 3, 3, W'(16'hA5), 1'b1, '0, 20);

    // Mode 3, LSB-first, slave returns 0x5A6.
    run_txn("mode3", 0, 12, 1'b1, 1'b1, 1'b1, 1, 2, 2, W'(16'h3C1), 1'b0,
            W'(16'h5A6), 2);
    check("mode3 sclk_idle_after", W'(sclk), W'(1));

    // Full width, fastest clock, alternating pattern.
    alt = {(W / 2){2'b10}};
    run_txn("full256", 3, W, 1'b0, 1'b0, 1'b0, 1, 0, 0, alt, 1'b1, '0, 1);

    // Rejected requests, one at a time.
    bad_req("bad_cs", 4, 8, 2);
    bad_req("bad_nbits0", 0, 0, 2);
    bad_req("bad_nbits257", 0, W + 1, 2);
    bad_req("bad_nhalf0", 0, 8, 0);

    // Valid request after rejections clears err.
    run_txn("after_bad", 2, 5, 1'b0, 1'b1, 1'b0, 3, 1, 1, rand_word(), 1'b0,
            rand_word(), 0);

    // Reset in the middle of a 16-bit transfer.
    cs_sel   = 8'd2;
    nbits    = 16'd16;
    cpol     = 1'b0;
    cpha     = 1'b0;
    lsb_first = 1'b0;
    n_half   = CW'(2);
    n_setup  = CW'(1);
    n_hold   = CW'(1);
    wr_data  = W'(16'hBEEF);
    loopback = 1'b1;
    s_cpha   = 1'b0;
    s_lsb    = 1'b0;
    s_nbits  = 16;
    t0       = tog_total;
    req      = 1'b1;
    got      = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      tick(1);
      if (tog_total - t0 >= 9) got = 1'b1;
    end
    check("midrst reach_bit5", W'(got), W'(1));
    rst = 1'b1;
    #1;
    check("midrst cs_n", W'(cs_n), W'({NCS{1'b1}}));
    check("midrst busy", W'(busy), W'(0));
    check("midrst ack", W'(ack), W'(0));
    check("midrst sclk", W'(sclk), W'(0));
    check("midrst mosi", W'(mosi), W'(0));
    req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    last_rd = '0;
    check("midrst rd_data", rd_data, last_rd);
    run_txn("post_rst", 1, 8, 1'b0, 1'b0, 1'b0, 2, 2, 2, W'(16'h3C), 1'b1, '0, 0);

    // Randomised transactions.
    for (int r = 0; r < 10; r++) begin
      int nb;
      nb = (r == 9) ? W : int'($urandom_range(1, 48));
      run_txn($sformatf("rand%0d", r), int'($urandom_range(0, NCS - 1)), nb,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              rand_word(), 1'($urandom_range(0, 1)), rand_word(),
              int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
